// File: rtl/fifo_stim_driver_pkg.sv
// Shared types and helpers for the FIFO stimulus driver: phase encoding,
// LFSR taps and saturating counter step.
package fifo_stim_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_OVF   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_UNF   = 3'd4,
    ST_MIXED = 3'd5,
    ST_DONE  = 3'd6
  } drv_state_e;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur[0] == 1'b1) ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cur, input logic en);
    return (en && (cur != 16'hFFFF)) ? (cur + 16'd1) : cur;
  endfunction

endpackage

// File: rtl/fifo_stim_driver_lfsr.sv
// 16-bit Galois LFSR supplying write data and random enables; reset loads the seed.
module fifo_drv_lfsr
  import fifo_stim_driver_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    if (step) begin
      q_d = lfsr_next(q_q);
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fifo_stim_driver.sv
// FIFO traffic driver: fill / overflow probe / drain / underflow probe / mixed.
// Define FIFO_DRV_RAND_EN for LFSR-driven enables in the mixed phase.
module fifo_stim_driver
  import fifo_stim_driver_pkg::*;
#(
  parameter int          FIFO_WIDTH   = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          MIXED_CYCLES = 64,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_in,
  output logic [2:0]            phase,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count,
  output logic                  done,
  output logic                  err
);

  localparam logic [15:0] WD_LIMIT = 16'(2 * FIFO_DEPTH + 4);
  localparam logic [15:0] MIX_LAST = 16'(MIXED_CYCLES - 1);

  drv_state_e            state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [FIFO_WIDTH-1:0] data_in_q, data_in_d;
  logic [15:0]           wr_count_q, wr_count_d;
  logic [15:0]           rd_count_q, rd_count_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  lfsr_step;
  logic [15:0]           lfsr_q;

  fifo_drv_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (lfsr_step),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    cnt_d      = cnt_q + 16'd1;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    data_in_d  = data_in_q;
    lfsr_step  = 1'b0;
    wr_count_d = sat_inc(wr_count_q, wr_ack);
    rd_count_d = sat_inc(rd_count_q, rd_en_q & ~empty);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (full) begin
          state_d = ST_OVF;
        end else if (cnt_q >= WD_LIMIT) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_OVF: begin
        err_d   = err_q | ~overflow;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (empty) begin
          state_d = ST_UNF;
        end else if (cnt_q >= WD_LIMIT) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_UNF: begin
        err_d   = err_q | ~underflow;
        state_d = ST_MIXED;
      end
      ST_MIXED: begin
        if (cnt_q == MIX_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Phase counter restarts on every transition; idle/done never count
    if ((state_d != state_q) || (state_d == ST_IDLE) || (state_d == ST_DONE)) begin
      cnt_d = 16'd0;
    end

    // Enables are registered, so they follow the state being entered
    case (state_d)
      ST_FILL, ST_OVF: begin
        wr_en_d = 1'b1;
      end
      ST_DRAIN, ST_UNF: begin
        rd_en_d = 1'b1;
      end
      ST_MIXED: begin
`ifdef FIFO_DRV_RAND_EN
        wr_en_d   = lfsr_q[0];
        rd_en_d   = lfsr_q[1];
        lfsr_step = 1'b1;
`else
        case (cnt_d[1:0])
          2'd0: begin
            wr_en_d = 1'b1;
          end
          2'd1: begin
            wr_en_d = 1'b1;
            rd_en_d = 1'b1;
          end
          2'd2: begin
            rd_en_d = 1'b1;
          end
          default: begin
            wr_en_d = 1'b0;
          end
        endcase
`endif
      end
      default: begin
        wr_en_d = 1'b0;
      end
    endcase

    if (wr_en_d) begin
      data_in_d = FIFO_WIDTH'(lfsr_q);
      lfsr_step = 1'b1;
    end

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      data_in_q  <= '0;
      wr_count_q <= 16'd0;
      rd_count_q <= 16'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      data_in_q  <= data_in_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign rd_en    = rd_en_q;
  assign data_in  = data_in_q;
  assign phase    = state_q;
  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fifo_stim_driver.sv
// Bench for fifo_stim_driver: a depth-8 FIFO model with fault ties, a phase
// scoreboard fed by the stimulus, and a monitor popping on every phase change.
module tb_fifo_stim_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        full, empty, wr_ack, overflow, underflow;
  logic        wr_en, rd_en;
  logic [15:0] data_in;
  logic [2:0]  phase;
  logic [15:0] wr_count, rd_count;
  logic        done, err;

  logic        tie_full0 = 1'b0;
  logic        tie_ovf0  = 1'b0;
  logic [3:0]  f_cnt;
  logic        full_int, ovf_r;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [2:0]  ph;
    logic [15:0] wc;
    logic [15:0] rc;
    logic        er;
    logic        dn;
    logic        we;
    logic        re;
  } rec_t;

  rec_t        expq[$];
  logic [15:0] wdq[$];

  always #5 clk = ~clk;

  fifo_stim_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .full      (full),
    .empty     (empty),
    .wr_ack    (wr_ack),
    .overflow  (overflow),
    .underflow (underflow),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .data_in   (data_in),
    .phase     (phase),
    .wr_count  (wr_count),
    .rd_count  (rd_count),
    .done      (done),
    .err       (err)
  );

  // Reference FIFO: combinational full/empty, registered handshake flags
  assign full_int = (f_cnt == 4'd8);
  assign empty    = (f_cnt == 4'd0);
  assign full     = tie_full0 ? 1'b0 : full_int;
  assign overflow = tie_ovf0 ? 1'b0 : ovf_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_cnt     <= 4'd0;
      wr_ack    <= 1'b0;
      ovf_r     <= 1'b0;
      underflow <= 1'b0;
    end else begin
      f_cnt     <= f_cnt + 4'((wr_en && !full_int) ? 1 : 0) - 4'((rd_en && !empty) ? 1 : 0);
      wr_ack    <= wr_en && !full_int;
      ovf_r     <= wr_en && full_int;
      underflow <= rd_en && empty;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic [2:0] ph, input logic [15:0] wc, input logic [15:0] rc,
                              input logic er, input logic dn, input logic we, input logic re);
    rec_t r;
    r.ph = ph; r.wc = wc; r.rc = rc; r.er = er; r.dn = dn; r.we = we; r.re = re;
    return r;
  endfunction

  // Hand-derived outcome of a complete run on an initially empty depth-8 FIFO
  task automatic push_normal(input logic ovf_err);
    expq.push_back(mk(3'd1, 16'd0,  16'd0,  1'b0,    1'b0, 1'b1, 1'b0));
    expq.push_back(mk(3'd2, 16'd8,  16'd0,  1'b0,    1'b0, 1'b1, 1'b0));
    expq.push_back(mk(3'd3, 16'd8,  16'd0,  ovf_err, 1'b0, 1'b0, 1'b1));
    expq.push_back(mk(3'd4, 16'd8,  16'd8,  ovf_err, 1'b0, 1'b0, 1'b1));
    expq.push_back(mk(3'd5, 16'd8,  16'd8,  ovf_err, 1'b0, 1'b1, 1'b0));
    expq.push_back(mk(3'd6, 16'd40, 16'd40, ovf_err, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_phase(input logic [2:0] tgt, input int lim);
    int n = 0;
    while (phase !== tgt && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_phase_timeout", 32'(phase), 32'(tgt));
  endtask

  task automatic do_reset();
    expq.push_back(mk(3'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_phase"}, 32'(phase), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_data"},  32'(data_in), 32'd0);
    chk({tag, "_wrc"},   32'(wr_count), 32'd0);
    chk({tag, "_rdc"},   32'(rd_count), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_err"},   32'(err), 32'd0);
  endtask

  // Monitor: compares state snapshot on each phase change, and write data on accepted writes
  initial begin
    logic [2:0] prev_ph;
    rec_t       r;
    prev_ph = 3'd0;
    wait (rst_n === 1'b1);
    forever begin
      @(negedge clk);
      if (phase !== prev_ph) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_phase: got %0d after %0d with no expectation", phase, prev_ph);
        end else begin
          r = expq.pop_front();
          chk("sb_phase", 32'(phase), 32'(r.ph));
          chk("sb_wr_count", 32'(wr_count), 32'(r.wc));
          chk("sb_rd_count", 32'(rd_count), 32'(r.rc));
          chk("sb_err", 32'(err), 32'(r.er));
          chk("sb_done", 32'(done), 32'(r.dn));
          chk("sb_wr_en", 32'(wr_en), 32'(r.we));
          chk("sb_rd_en", 32'(rd_en), 32'(r.re));
        end
        prev_ph = phase;
      end
      if (wr_en && !full_int && wdq.size() > 0) begin
        chk("wdata", 32'(data_in), 32'(wdq.pop_front()));
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Normal run with the first eight LFSR words checked on the write side
    push_normal(1'b0);
    wdq.push_back(16'hACE1); wdq.push_back(16'hE270); wdq.push_back(16'h7138);
    wdq.push_back(16'h389C); wdq.push_back(16'h1C4E); wdq.push_back(16'h0E27);
    wdq.push_back(16'hB313); wdq.push_back(16'hED89);
    pulse_start();
    wait_phase(3'd6, 200);
    chk("wdq_drained", 32'(wdq.size()), 32'd0);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("done_holds_phase", 32'(phase), 32'd6);
    chk("done_holds_enables", 32'({wr_en, rd_en}), 32'd0);
    do_reset();

    // Overflow never flagged by the FIFO
    tie_ovf0 = 1'b1;
    push_normal(1'b1);
    pulse_start();
    wait_phase(3'd6, 200);
    tie_ovf0 = 1'b0;
    do_reset();

    // Full never flagged: watchdog ends FILL after 21 cycles
    tie_full0 = 1'b1;
    expq.push_back(mk(3'd1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    expq.push_back(mk(3'd6, 16'd8, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("watchdog_cycles", 32'(n), 32'd21);
    @(negedge clk);
    tie_full0 = 1'b0;
    do_reset();

    // Reset in the middle of DRAIN, then restart
    expq.push_back(mk(3'd1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    expq.push_back(mk(3'd2, 16'd8, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    expq.push_back(mk(3'd3, 16'd8, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    expq.push_back(mk(3'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    pulse_start();
    wait_phase(3'd3, 50);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_drain_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", 32'(phase), 32'd0);
    push_normal(1'b0);
    wdq.push_back(16'hACE1);
    wdq.push_back(16'hE270);
    pulse_start();
    chk("restart_data_seed", 32'(data_in), 32'hACE1);
    chk("restart_wr_en", 32'(wr_en), 32'd1);
    wait_phase(3'd6, 200);

    @(negedge clk);
    chk("scoreboard_empty", 32'(expq.size()), 32'd0);
    chk("wdq_empty", 32'(wdq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
